// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I core types and constants.
//   XLEN / ALEN      : data and address widths.
//   NOP_A            : canonical NOP (addi x0, x0, 0) used for bubbles and faulted fetches.
//   RAM_MEMORY_SIZE  : instruction RAM depth in 32-bit words.
//   if_id_t          : IF/ID pipeline register payload.
//   IF_ID_BUBBLE     : IF/ID contents for an empty slot.
//   fetch_fault()    : true when a fetch address is misaligned or outside RAM.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int ALEN            = 32;
  localparam int RAM_MEMORY_SIZE = 1024;

  localparam logic [XLEN-1:0] NOP_A = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [ALEN-1:0] pc;
    logic [ALEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            fault;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid:    1'b0,
    pc:       '0,
    pc_plus4: '0,
    instr:    NOP_A,
    fault:    1'b0
  };

  function automatic logic fetch_fault(input logic [ALEN-1:0] addr);
    logic [ALEN-1:0] word_idx;
    word_idx = {2'b00, addr[ALEN-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= ALEN'(RAM_MEMORY_SIZE));
  endfunction

endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-low reset (loads IF_ID_BUBBLE)
//   stall in   hold current contents
//   flush in   load IF_ID_BUBBLE (wins over stall)
//   d     in   next IF/ID payload
//   q     out  current IF/ID payload
module if_id_register
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the five-stage RV32I pipeline.
//   RESET_PC        param  PC loaded on reset (4-byte aligned)
//   clk             in     rising-edge clock
//   rst             in     synchronous active-low reset
//   stall           in     hold PC and IF/ID
//   redirect        in     taken branch/jump: flush IF/ID, load redirect_pc
//   redirect_pc     in     redirect target
//   imem_en         out    instruction memory enable
//   imem_addr       out    fetch byte address (= pc)
//   imem_instr      in     instruction for imem_addr (combinational)
//   if_id_valid     out    IF/ID holds a real instruction
//   if_id_pc        out    PC of IF/ID instruction
//   if_id_pc_plus4  out    if_id_pc + 4
//   if_id_instr     out    IF/ID instruction word
//   if_id_fault     out    fetch was misaligned or beyond RAM
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [ALEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [ALEN-1:0] redirect_pc,
  output logic            imem_en,
  output logic [ALEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic            if_id_valid,
  output logic [ALEN-1:0] if_id_pc,
  output logic [ALEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_fault
);

  logic [ALEN-1:0] pc;
  logic [ALEN-1:0] pc_plus4;
  logic            fault;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign pc_plus4  = pc + ALEN'(4);
  assign fault     = fetch_fault(pc);
  assign imem_addr = pc;
  assign imem_en   = rst & ~stall;

  // Program counter: reset > redirect > stall > sequential (wraps silently)
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // Faulted fetches still advance but carry a NOP so decode never sees garbage
  always_comb begin
    if_id_d          = IF_ID_BUBBLE;
    if_id_d.valid    = 1'b1;
    if_id_d.pc       = pc;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.instr    = fault ? NOP_A : imem_instr;
    if_id_d.fault    = fault;
  end

  // IF/ID boundary
  if_id_register u_if_id (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (redirect),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_valid    = if_id_q.valid;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_fault    = if_id_q.fault;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam longint RAM_WORDS = 1024;
  localparam longint TWO32     = 64'h1_0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_fault    (if_id_fault)
  );

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        en;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (plain integers)
  longint m_pc = 0;
  bit     m_valid = 0;
  longint m_ipc = 0;
  longint m_ipc4 = 0;
  longint m_instr = 0;
  bit     m_fault = 0;

  // Apply one cycle of inputs (called just after a falling edge) and queue
  // the outputs expected after the following rising edge.
  task automatic step(input string tag, input bit r, input bit s, input bit rd,
                      input logic [31:0] rpc);
    exp_t e;
    bit   bad;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    if (!r) begin
      m_pc = 0; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_fault = 0;
    end else if (rd) begin
      m_pc = rpc; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_fault = 0;
    end else if (!s) begin
      bad     = (m_pc % 4 != 0) || (m_pc / 4 >= RAM_WORDS);
      m_valid = 1;
      m_ipc   = m_pc;
      m_ipc4  = (m_pc + 4) % TWO32;
      m_instr = bad ? NOP : mem_word(m_pc[31:0]);
      m_fault = bad;
      m_pc    = (m_pc + 4) % TWO32;
    end
    e.tag = tag; e.addr = m_pc[31:0]; e.en = r && !s;
    e.valid = m_valid; e.pc = m_ipc[31:0]; e.pc4 = m_ipc4[31:0];
    e.instr = m_instr[31:0]; e.fault = m_fault;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every rising edge's outputs against the queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [130:0] act, req;
      e   = exp_q.pop_front();
      act = {imem_addr, imem_en, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_fault};
      req = {e.addr, e.en, e.valid, e.pc, e.pc4, e.instr, e.fault};
      n_cmp++;
      if (act !== req) begin
        n_bad++;
        $display("FAIL %s: got addr=%h en=%b v=%b pc=%h pc4=%h ins=%h f=%b want addr=%h en=%b v=%b pc=%h pc4=%h ins=%h f=%b",
                 e.tag, imem_addr, imem_en, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_fault,
                 e.addr, e.en, e.valid, e.pc, e.pc4, e.instr, e.fault);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    @(negedge clk);
    // Reset and sequential fetch from 0
    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("seq", 1, 0, 0, 0);
    // Stall for three cycles, then resume
    for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step("resume", 1, 0, 0, 0);
    // Redirect overriding stall
    step("redir_stall", 1, 1, 1, 32'h40);
    for (int i = 0; i < 3; i++) step("after_redir", 1, 0, 0, 0);
    // Misaligned target
    step("redir_mis", 1, 0, 1, 32'h42);
    for (int i = 0; i < 2; i++) step("misaligned", 1, 0, 0, 0);
    // Crossing the end of RAM
    step("redir_end", 1, 0, 1, 32'(RAM_WORDS * 4 - 8));
    for (int i = 0; i < 4; i++) step("ram_end", 1, 0, 0, 0);
    // PC wrap at 2^32
    step("redir_wrap", 1, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) step("wrap", 1, 0, 0, 0);
    // Reset beats a simultaneous redirect
    step("reset_vs_redir", 0, 1, 1, 32'h100);
    for (int i = 0; i < 2; i++) step("post_reset", 1, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = {20'h0, $urandom_range(0, 1023), 2'b00};
        1:       rpc = $urandom;
        2:       rpc = 32'(RAM_WORDS * 4) - 32'($urandom_range(0, 4) * 4);
        default: rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      step("random", $urandom_range(0, 31) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, rpc);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
